// File: rtl/data_mem_unit_pkg.sv
// Shared encodings for the data memory unit: access sizes and FSM states.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    RSP  = 2'b10
  } state_e;

endpackage

// File: rtl/data_mem_unit_load_align.sv
// Load lane select: picks the byte/half/word from a 32-bit memory word
// and sign- or zero-extends it to 32 bits.
module load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lo_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Select the addressed lane and extend it to a full word.
  always_comb begin
    byte_v = word_i[8*lo_i +: 8];
    half_v = lo_i[1] ? word_i[31:16] : word_i[15:0];
    data_o = word_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{sext_i & byte_v[7]}}, byte_v};
      SZ_HALF: data_o = {{16{sext_i & half_v[15]}}, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Word-organised data memory with a req/ready handshake, byte/half/word
// access, load extension and registered rvalid/rdata/err outputs.
// Loads take 2 cycles (IDLE->RD->RSP), stores commit on accept and take 1.
module data_mem_unit
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  output logic          ready,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          sign_ext,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          rvalid,
  output logic [31:0]   rdata,
  output logic          err
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);

  state_e         state_q, state_d;
  logic           accept;
  logic           misalign;
  logic [3:0]     be;
  logic [31:0]    wlane;
  logic [IW-1:0]  idx;

  logic [IW-1:0]  idx_q;
  logic [1:0]     lo_q;
  logic [1:0]     size_q;
  logic           sext_q;
  logic           we_q;
  logic           mis_q;

  logic [31:0]    mem [DEPTH_WORDS];
  logic [31:0]    rword_q;
  logic [31:0]    ld_data;

  logic           rvalid_q, rvalid_d;
  logic           err_q, err_d;
  logic [31:0]    rdata_q, rdata_d;

  // Upper address bits alias and are intentionally ignored.
  logic           unused_addr;
  assign unused_addr = ^addr[AW-1:IW+2];

  assign idx    = addr[IW+1:2];
  assign ready  = (state_q == IDLE);
  assign accept = req && ready;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

  // Alignment check, byte enables and lane-replicated store data.
  always_comb begin
    misalign = 1'b0;
    be       = '0;
    wlane    = wdata;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        misalign = addr[0];
        be       = 4'b0011 << addr[1:0];
        wlane    = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        misalign = |addr[1:0];
        be       = '1;
      end
      default: misalign = 1'b1;
    endcase
    if (misalign) be = '0;
  end

  // Array: byte-enabled write on store accept, synchronous read in RD.
  always_ff @(posedge clk) begin
    if (accept && we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
    if (state_q == RD) rword_q <= mem[idx_q];
  end

  load_align u_load_align (
    .word_i (rword_q),
    .lo_i   (lo_q),
    .size_i (size_q),
    .sext_i (sext_q),
    .data_o (ld_data)
  );

  // Next state and registered response values.
  always_comb begin
    state_d  = state_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: if (accept) state_d = we ? RSP : RD;
      RD:   state_d = RSP;
      RSP: begin
        state_d  = IDLE;
        rvalid_d = 1'b1;
        err_d    = mis_q;
        if (mis_q)      rdata_d = '0;
        else if (!we_q) rdata_d = ld_data;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, response outputs and request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      idx_q    <= '0;
      lo_q     <= '0;
      size_q   <= '0;
      sext_q   <= 1'b0;
      we_q     <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      if (accept) begin
        idx_q  <= idx;
        lo_q   <= addr[1:0];
        size_q <= size;
        sext_q <= sign_ext;
        we_q   <= we;
        mis_q  <= misalign;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: expected responses are queued at
// accept and compared (data, err, latency) when rvalid pulses.
module tb_data_mem_unit;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        ready;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH_WORDS(256), .AW(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ready    (ready),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .err      (err)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned ecount   = 0;

  always @(posedge clk) ecount++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        er;
    logic        chk;
    int unsigned edge_n;
  } exp_t;

  exp_t sb[$];

  // Response monitor: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rvalid) begin
      if (sb.size() == 0) begin
        check("spurious_rvalid", {31'b0, rvalid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_lat"}, ecount, e.edge_n);
        check({e.tag, "_err"}, {31'b0, err}, {31'b0, e.er});
        if (e.chk) check({e.tag, "_rdata"}, rdata, e.rd);
      end
    end
  end

  // Drive a request (req left high) and queue its expected response.
  task automatic issue(input string tag, input logic w, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_er);
    exp_t e;
    int unsigned n;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check({tag, "_ready_timeout"}, {31'b0, ready}, 32'd1);
      req = 1'b0;
      return;
    end
    e.tag    = tag;
    e.rd     = exp_rd;
    e.er     = exp_er;
    e.chk    = !w || exp_er;
    e.edge_n = ecount + 1 + (w ? 1 : 2);
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic drain();
    int unsigned n;
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = SZ_WORD; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",  {31'b0, ready},  32'd1);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_rdata",  rdata,           32'd0);
    check("rst_err",    {31'b0, err},    32'd0);
    rst_n = 1'b1;

    // Word store then back-to-back load (read-after-write).
    issue("st_w10",  1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    issue("ld_w10",  0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    drain();

    // Byte store and extended byte loads.
    issue("st_b13",  1, SZ_BYTE, 0, 32'h13, 32'h00000080, 32'h0, 0);
    issue("ld_b13s", 0, SZ_BYTE, 1, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    issue("ld_b13z", 0, SZ_BYTE, 0, 32'h13, 32'h0, 32'h00000080, 0);
    issue("ld_w10b", 0, SZ_WORD, 1, 32'h10, 32'h0, 32'h80ADBEEF, 0);
    drain();

    // Half store leaves the other half intact.
    issue("st_w20",  1, SZ_WORD, 0, 32'h20, 32'hAABBCCDD, 32'h0, 0);
    issue("st_h22",  1, SZ_HALF, 0, 32'h22, 32'h00001234, 32'h0, 0);
    issue("ld_h22s", 0, SZ_HALF, 1, 32'h22, 32'h0, 32'h00001234, 0);
    issue("ld_w20",  0, SZ_WORD, 0, 32'h20, 32'h0, 32'h1234CCDD, 0);
    issue("ld_b21z", 0, SZ_BYTE, 0, 32'h21, 32'h0, 32'h000000CC, 0);
    issue("ld_h20s", 0, SZ_HALF, 1, 32'h20, 32'h0, 32'hFFFFCCDD, 0);
    drain();

    // Misaligned and illegal-size accesses.
    issue("ld_w11",  0, SZ_WORD, 0, 32'h11, 32'h0, 32'h0, 1);
    issue("st_h23",  1, SZ_HALF, 0, 32'h23, 32'h00005555, 32'h0, 1);
    issue("ld_w20m", 0, SZ_WORD, 0, 32'h20, 32'h0, 32'h1234CCDD, 0);
    issue("ld_sz3",  0, 2'b11,   0, 32'h20, 32'h0, 32'h0, 1);
    drain();

    // Address aliasing modulo 1 KiB.
    issue("st_w400", 1, SZ_WORD, 0, 32'h400, 32'h0BADF00D, 32'h0, 0);
    issue("ld_w000", 0, SZ_WORD, 0, 32'h000, 32'h0, 32'h0BADF00D, 0);
    drain();

    // req held high across a mixed stream; only ready cycles accept.
    issue("st_w404", 1, SZ_WORD, 0, 32'h404, 32'h11223344, 32'h0, 0);
    issue("ld_b405", 0, SZ_BYTE, 1, 32'h405, 32'h0, 32'h00000033, 0);
    issue("ld_h406", 0, SZ_HALF, 0, 32'h406, 32'h0, 32'h00001122, 0);
    issue("st_b404", 1, SZ_BYTE, 0, 32'h404, 32'h000000FF, 32'h0, 0);
    issue("ld_w404", 0, SZ_WORD, 0, 32'h404, 32'h0, 32'h112233FF, 0);
    drain();

    // Reset during RD aborts the load without a response.
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = SZ_WORD; sign_ext = 1'b0; addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("rd_ready_low", {31'b0, ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_ready",  {31'b0, ready},  32'd1);
    check("arst_rvalid", {31'b0, rvalid}, 32'd0);
    check("arst_rdata",  rdata,           32'd0);
    check("arst_err",    {31'b0, err},    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("post_rst_ready",  {31'b0, ready},  32'd1);

    // Committed stores survive reset.
    issue("ld_w404r", 0, SZ_WORD, 0, 32'h404, 32'h0, 32'h112233FF, 0);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
